vga_fifo_health_monitor: RTL and testbench
==========================================

// Module: vga_fifo_health_monitor
// PURPOSE
//  Synthesisable, parametrised run-time monitor for the VGA core's FIFO and Wishbone-slave handshakes.
//  Replaces simulation-only checking of line/data FIFO underrun and stb/ack with sticky flags,
//  saturating counters, a first-error capture and a maskable interrupt readable by software.
//  Sits in the wb_clk_i domain beside the register file; any pixel-clock events are synchronised upstream.
// PARAMETERS
//  NCH      2   number of monitored FIFO channels (1..8)
//  CNT_W    8   width of each per-channel saturating event counter
//  HOLDOFF  4   cycles after ctrl_ven rises during which all events are ignored (0 = none)
// PORTS
//  wb_clk_i      in   1          single clock; all logic on rising edge
//  rst_i         in   1          reset, synchronous, active-high
//  ctrl_ven      in   1          video enable; low = monitor held cleared
//  fifo_wreq     in   NCH        per-channel write request
//  fifo_rreq     in   NCH        per-channel read request
//  fifo_full     in   NCH        per-channel full
//  fifo_empty    in   NCH        per-channel empty
//  wbs_stb_i     in   1          Wishbone slave strobe (observed)
//  wbs_ack_o     in   1          Wishbone slave ack (observed)
//  clr_i         in   NCH        write-1-clear of channel flags and counters (one-cycle pulse)
//  irq_mask_i    in   NCH        1 = channel excluded from irq_o
//  uflow_o       out  NCH        sticky underrun flag
//  oflow_o       out  NCH        sticky overflow flag
//  uflow_cnt_o   out  NCH*CNT_W  underrun counters, channel i at [i*CNT_W +: CNT_W]
//  oflow_cnt_o   out  NCH*CNT_W  overflow counters, same packing
//  proto_err_o   out  1          sticky Wishbone handshake error
//  first_vld_o   out  1          first_code_o holds a captured error
//  first_code_o  out  4          {type[0]=1 oflow/0 uflow, ch[2:0]} of first error
//  irq_o         out  1          interrupt
// BEHAVIOUR
//  - Reset or ctrl_ven=0: every output, counter, flag and holdoff timer = 0; events ignored.
//  - On ctrl_ven 0->1 the holdoff counter loads HOLDOFF; events are ignored while it is nonzero.
//  - Armed = ctrl_ven & holdoff==0. Events sampled in cycle t, registered result visible in t+1:
//      underrun[i] = rreq[i] & empty[i];  overflow[i] = wreq[i] & full[i].
//  - Flag set on event; cleared only by clr_i[i], rst_i or ctrl_ven=0. Event and clr same cycle: flag stays 1.
//  - Counter +1 per event-cycle, saturates at 2^CNT_W-1 (no wrap). Clear and event in the same cycle: counter = 1.
//    Clear alone: counter = 0.
//  - proto_err_o set (armed only) when wbs_ack_o & ~wbs_stb_i, or when stb falls (prev stb=1, now 0) while prev ack=0.
//    Cleared only by rst_i or ctrl_ven=0.
//  - First-error capture: when first_vld_o=0 and any event occurs, latch the lowest channel with an event;
//    underrun has priority over overflow on that channel. first_vld_o goes to 1 in t+1.
//    Held until all uflow_o/oflow_o are 0 after a clear, then re-arms on the next cycle.
//  - irq_o registered: irq_o(t+1) = |((uflow|oflow)(t+1) & ~irq_mask_i(t)) | proto_err(t+1).
//    Event in t gives irq_o=1 in t+1.
//  - Unused first_code_o channel bits are 0 when NCH < 8.
// TESTING
//  - Reset, ctrl_ven=0, toggle rreq with empty=1 -> all outputs stay 0 throughout.
//  - ctrl_ven rises at t0 with HOLDOFF=4, rreq0 & empty0 from t0 -> first count in cycle t0+5; uflow_o[0]=1 and irq_o=1.
//  - Hold wreq1 & full1 for 300 cycles at CNT_W=8 -> oflow_cnt ch1 = 255 and stays 255; first_code_o = 4'b1001.
//  - Same cycle: underrun on ch1 and ch0 -> first_code_o = 4'b0000.
//    Then clr_i=2'b01 together with a new ch0 event -> uflow_o[0]=1, ch0 counter = 1.
//  - irq_mask_i=2'b01, only ch0 events -> irq_o=0. Then ack=1 with stb=0 -> proto_err_o=1 and irq_o=1 next cycle.
//  - Mid-operation rst_i=1 for one cycle with flags set -> every output 0 the following cycle.

Source files
------------

// File: rtl/vga_fifo_health_monitor_if.sv
// Handshake bundle between the VGA FIFO/Wishbone fabric and the health monitor.
// master drives the observed events and controls; slave is the monitor itself.
interface vga_fifo_health_monitor_if #(
    parameter int NCH   = 2,
    parameter int CNT_W = 8
);
    logic [NCH-1:0]       fifo_wreq;
    logic [NCH-1:0]       fifo_rreq;
    logic [NCH-1:0]       fifo_full;
    logic [NCH-1:0]       fifo_empty;
    logic                 wbs_stb_i;
    logic                 wbs_ack_o;
    logic [NCH-1:0]       clr_i;
    logic [NCH-1:0]       irq_mask_i;
    logic [NCH-1:0]       uflow_o;
    logic [NCH-1:0]       oflow_o;
    logic [NCH*CNT_W-1:0] uflow_cnt_o;
    logic [NCH*CNT_W-1:0] oflow_cnt_o;
    logic                 proto_err_o;
    logic                 first_vld_o;
    logic [3:0]           first_code_o;
    logic                 irq_o;

    modport master (
        output fifo_wreq, fifo_rreq, fifo_full, fifo_empty,
        output wbs_stb_i, wbs_ack_o, clr_i, irq_mask_i,
        input  uflow_o, oflow_o, uflow_cnt_o, oflow_cnt_o,
        input  proto_err_o, first_vld_o, first_code_o, irq_o
    );

    modport slave (
        input  fifo_wreq, fifo_rreq, fifo_full, fifo_empty,
        input  wbs_stb_i, wbs_ack_o, clr_i, irq_mask_i,
        output uflow_o, oflow_o, uflow_cnt_o, oflow_cnt_o,
        output proto_err_o, first_vld_o, first_code_o, irq_o
    );
endinterface

// File: rtl/vga_fifo_health_monitor.sv
// Run-time FIFO underrun/overflow and Wishbone stb/ack monitor with sticky flags,
// saturating counters, first-error capture and a maskable interrupt.
module vga_fifo_health_monitor #(
    parameter int NCH     = 2,
    parameter int CNT_W   = 8,
    parameter int HOLDOFF = 4
) (
    input  logic                        wb_clk_i,
    input  logic                        rst_i,
    input  logic                        ctrl_ven,
    vga_fifo_health_monitor_if.slave    bus
);
    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                 ven_q, stb_q, ack_q;
    logic [HW-1:0]        hold_q;
    logic                 armed;
    logic [NCH-1:0]       uev, oev;
    logic [NCH-1:0]       uflow_q, oflow_q, uflow_d, oflow_d;
    logic [CNT_W-1:0]     ucnt_q [NCH];
    logic [CNT_W-1:0]     ocnt_q [NCH];
    logic [CNT_W-1:0]     ucnt_d [NCH];
    logic [CNT_W-1:0]     ocnt_d [NCH];
    logic                 proto_q, proto_d;
    logic                 fvld_q, fvld_d;
    logic [3:0]           fcode_q, fcode_d;
    logic                 irq_q, irq_d;

    function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                  input logic ev, input logic clr);
        if (clr)
            return ev ? CNT_W'(1) : '0;
        return (ev && cnt != CNT_MAX) ? cnt + CNT_W'(1) : cnt;
    endfunction

    // The rise cycle itself is ignored whenever a holdoff is configured.
    assign armed = ctrl_ven && (hold_q == '0) && (ven_q || HOLDOFF == 0);

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        uev     = armed ? (bus.fifo_rreq & bus.fifo_empty) : '0;
        oev     = armed ? (bus.fifo_wreq & bus.fifo_full)  : '0;
        uflow_d = (uflow_q & ~bus.clr_i) | uev;
        oflow_d = (oflow_q & ~bus.clr_i) | oev;
        for (int i = 0; i < NCH; i++) begin
            ucnt_d[i] = next_cnt(ucnt_q[i], uev[i], bus.clr_i[i]);
            ocnt_d[i] = next_cnt(ocnt_q[i], oev[i], bus.clr_i[i]);
        end
        proto_d = proto_q | (armed && ((bus.wbs_ack_o && !bus.wbs_stb_i) ||
                                       (stb_q && !bus.wbs_stb_i && !ack_q)));
        fvld_d  = fvld_q;
        fcode_d = fcode_q;
        if (fvld_q) begin
            if ((uflow_q | oflow_q) == '0) begin
                fvld_d  = 1'b0;
                fcode_d = '0;
            end
        end else if ((uev | oev) != '0) begin
            fvld_d = 1'b1;
            // Descending scan: the lowest active channel is written last and wins.
            for (int i = NCH - 1; i >= 0; i--)
                if (uev[i] || oev[i])
                    fcode_d = {~uev[i], 3'(i)};
        end
        irq_d = (|((uflow_d | oflow_d) & ~bus.irq_mask_i)) | proto_d;
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (rst_i || !ctrl_ven) begin
            ven_q   <= 1'b0;
            stb_q   <= 1'b0;
            ack_q   <= 1'b0;
            hold_q  <= '0;
            uflow_q <= '0;
            oflow_q <= '0;
            proto_q <= 1'b0;
            fvld_q  <= 1'b0;
            fcode_q <= '0;
            irq_q   <= 1'b0;
            // NOTE: the counters are plain flops, not a RAM, so clearing them here is legal.
            for (int i = 0; i < NCH; i++) begin
                ucnt_q[i] <= '0;
                ocnt_q[i] <= '0;
            end
        end else begin
            ven_q   <= 1'b1;
            stb_q   <= bus.wbs_stb_i;
            ack_q   <= bus.wbs_ack_o;
            if (!ven_q)
                hold_q <= HW'(HOLDOFF);
            else if (hold_q != '0)
                hold_q <= hold_q - HW'(1);
            uflow_q <= uflow_d;
            oflow_q <= oflow_d;
            proto_q <= proto_d;
            fvld_q  <= fvld_d;
            fcode_q <= fcode_d;
            irq_q   <= irq_d;
            for (int i = 0; i < NCH; i++) begin
                ucnt_q[i] <= ucnt_d[i];
                ocnt_q[i] <= ocnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_pack
        assign bus.uflow_cnt_o[g*CNT_W +: CNT_W] = ucnt_q[g];
        assign bus.oflow_cnt_o[g*CNT_W +: CNT_W] = ocnt_q[g];
    end

    assign bus.uflow_o      = uflow_q;
    assign bus.oflow_o      = oflow_q;
    assign bus.proto_err_o  = proto_q;
    assign bus.first_vld_o  = fvld_q;
    assign bus.first_code_o = fcode_q;
    assign bus.irq_o        = irq_q;
endmodule

// File: tb/tb_vga_fifo_health_monitor.sv
// Directed + randomized bench for vga_fifo_health_monitor against a cycle-level
// behavioural model of the monitor's rules.
module tb_vga_fifo_health_monitor;
    localparam int NCH     = 2;
    localparam int CNT_W   = 8;
    localparam int HOLDOFF = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int DLY     = (HOLDOFF == 0) ? 0 : HOLDOFF + 1;

    logic clk = 1'b0;
    logic rst;
    logic ven;
    int   checks   = 0;
    int   failures = 0;

    vga_fifo_health_monitor_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

    vga_fifo_health_monitor #(.NCH(NCH), .CNT_W(CNT_W), .HOLDOFF(HOLDOFF)) dut (
        .wb_clk_i (clk),
        .rst_i    (rst),
        .ctrl_ven (ven),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference state
    int unsigned on_cnt;
    bit          m_uf [NCH];
    bit          m_of [NCH];
    int          m_uc [NCH];
    int          m_oc [NCH];
    bit          m_proto, m_pstb, m_pack, m_fvld, m_irq;
    int          m_fcode;

    task automatic model_step();
        bit armed, any_flag, found;
        bit ue [NCH];
        bit oe [NCH];
        if (rst || !ven) begin
            on_cnt = 0;
            for (int i = 0; i < NCH; i++) begin
                m_uf[i] = 0; m_of[i] = 0; m_uc[i] = 0; m_oc[i] = 0;
            end
            m_proto = 0; m_pstb = 0; m_pack = 0; m_fvld = 0; m_irq = 0; m_fcode = 0;
            return;
        end
        armed = (on_cnt >= DLY);
        if (on_cnt < 1000) on_cnt++;
        any_flag = 0;
        for (int i = 0; i < NCH; i++) begin
            any_flag |= m_uf[i] | m_of[i];
            ue[i] = armed && bus.fifo_rreq[i] && bus.fifo_empty[i];
            oe[i] = armed && bus.fifo_wreq[i] && bus.fifo_full[i];
        end
        if (m_fvld) begin
            if (!any_flag) begin m_fvld = 0; m_fcode = 0; end
        end else begin
            found = 0;
            for (int i = 0; i < NCH; i++)
                if (!found && (ue[i] || oe[i])) begin
                    found = 1; m_fvld = 1; m_fcode = (ue[i] ? 0 : 8) + i;
                end
        end
        for (int i = 0; i < NCH; i++) begin
            if (bus.clr_i[i]) begin
                m_uf[i] = ue[i]; m_uc[i] = ue[i] ? 1 : 0;
                m_of[i] = oe[i]; m_oc[i] = oe[i] ? 1 : 0;
            end else begin
                if (ue[i]) begin m_uf[i] = 1; if (m_uc[i] < CMAX) m_uc[i]++; end
                if (oe[i]) begin m_of[i] = 1; if (m_oc[i] < CMAX) m_oc[i]++; end
            end
        end
        if (armed && ((bus.wbs_ack_o && !bus.wbs_stb_i) || (m_pstb && !bus.wbs_stb_i && !m_pack)))
            m_proto = 1;
        m_pstb = bus.wbs_stb_i;
        m_pack = bus.wbs_ack_o;
        m_irq  = m_proto;
        for (int i = 0; i < NCH; i++)
            if ((m_uf[i] || m_of[i]) && !bus.irq_mask_i[i]) m_irq = 1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [NCH*CNT_W-1:0] eu, eo;
        logic [NCH-1:0]       fu, fo;
        for (int i = 0; i < NCH; i++) begin
            eu[i*CNT_W +: CNT_W] = CNT_W'(m_uc[i]);
            eo[i*CNT_W +: CNT_W] = CNT_W'(m_oc[i]);
            fu[i] = m_uf[i];
            fo[i] = m_of[i];
        end
        chk("uflow",      64'(bus.uflow_o),      64'(fu));
        chk("oflow",      64'(bus.oflow_o),      64'(fo));
        chk("uflow_cnt",  64'(bus.uflow_cnt_o),  64'(eu));
        chk("oflow_cnt",  64'(bus.oflow_cnt_o),  64'(eo));
        chk("proto_err",  64'(bus.proto_err_o),  64'(m_proto));
        chk("first_vld",  64'(bus.first_vld_o),  64'(m_fvld));
        chk("first_code", 64'(bus.first_code_o), 64'(m_fcode));
        chk("irq",        64'(bus.irq_o),        64'(m_irq));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        bus.fifo_wreq  = '0;
        bus.fifo_rreq  = '0;
        bus.fifo_full  = '0;
        bus.fifo_empty = '0;
    endtask

    task automatic clear_all();
        idle();
        bus.clr_i = '1;
        step();
        bus.clr_i = '0;
        step();
        step();
    endtask

    initial begin
        rst = 1'b1;
        ven = 1'b0;
        idle();
        bus.clr_i      = '0;
        bus.irq_mask_i = '0;
        bus.wbs_stb_i  = 1'b0;
        bus.wbs_ack_o  = 1'b0;
        step();
        step();
        chk("reset_irq", 64'(bus.irq_o), 64'(0));

        // Monitor disabled: events must be ignored.
        rst = 1'b0;
        repeat (10) begin
            bus.fifo_rreq  = NCH'($urandom);
            bus.fifo_empty = '1;
            bus.fifo_wreq  = NCH'($urandom);
            bus.fifo_full  = NCH'($urandom);
            step();
            chk("ven_off_flags", 64'({bus.uflow_o, bus.oflow_o, bus.irq_o}), 64'(0));
        end

        // Holdoff after the video-enable rise.
        idle();
        bus.fifo_rreq  = 2'b01;
        bus.fifo_empty = 2'b01;
        ven = 1'b1;
        repeat (HOLDOFF + 1) step();
        chk("holdoff_quiet", 64'(bus.uflow_cnt_o[CNT_W-1:0]), 64'(0));
        step();
        chk("holdoff_first_cnt", 64'(bus.uflow_cnt_o[CNT_W-1:0]), 64'(1));
        chk("holdoff_uflow0",    64'(bus.uflow_o[0]),             64'(1));
        chk("holdoff_irq",       64'(bus.irq_o),                  64'(1));

        // Counter saturation on channel 1 overflow.
        clear_all();
        bus.fifo_wreq = 2'b10;
        bus.fifo_full = 2'b10;
        repeat (300) step();
        chk("sat_cnt",  64'(bus.oflow_cnt_o[2*CNT_W-1:CNT_W]), 64'(255));
        chk("sat_code", 64'(bus.first_code_o),                 64'(4'b1001));
        step();
        chk("sat_hold", 64'(bus.oflow_cnt_o[2*CNT_W-1:CNT_W]), 64'(255));

        // Simultaneous underrun on both channels: lowest channel captured.
        clear_all();
        bus.fifo_rreq  = 2'b11;
        bus.fifo_empty = 2'b11;
        step();
        chk("simul_code", 64'(bus.first_code_o), 64'(4'b0000));
        chk("simul_vld",  64'(bus.first_vld_o),  64'(1));
        bus.fifo_rreq  = 2'b01;
        bus.fifo_empty = 2'b01;
        step();
        step();
        bus.clr_i = 2'b01;
        step();
        bus.clr_i = '0;
        chk("clr_evt_flag", 64'(bus.uflow_o[0]),             64'(1));
        chk("clr_evt_cnt",  64'(bus.uflow_cnt_o[CNT_W-1:0]), 64'(1));

        // Masked channel keeps irq low; a protocol error still raises it.
        clear_all();
        bus.irq_mask_i = 2'b01;
        bus.fifo_rreq  = 2'b01;
        bus.fifo_empty = 2'b01;
        repeat (4) begin
            step();
            chk("mask_irq", 64'(bus.irq_o), 64'(0));
        end
        idle();
        bus.wbs_ack_o = 1'b1;
        bus.wbs_stb_i = 1'b0;
        step();
        chk("proto_set", 64'(bus.proto_err_o), 64'(1));
        chk("proto_irq", 64'(bus.irq_o),       64'(1));
        bus.wbs_ack_o  = 1'b0;
        bus.irq_mask_i = '0;

        // Mid-operation reset with flags set.
        bus.fifo_wreq = 2'b11;
        bus.fifo_full = 2'b11;
        step();
        rst = 1'b1;
        idle();
        step();
        chk("rst_all", 64'({bus.uflow_o, bus.oflow_o, bus.uflow_cnt_o, bus.oflow_cnt_o,
                            bus.proto_err_o, bus.first_vld_o, bus.first_code_o, bus.irq_o}), 64'(0));
        rst = 1'b0;
        ven = 1'b0;
        step();
        ven = 1'b1;

        // Randomized phase against the model.
        repeat (800) begin
            rst = ($urandom_range(0, 99) == 0);
            ven = rst ? 1'b0 : ($urandom_range(0, 49) != 0);
            bus.fifo_rreq  = NCH'($urandom);
            bus.fifo_empty = NCH'($urandom);
            bus.fifo_wreq  = NCH'($urandom);
            bus.fifo_full  = NCH'($urandom);
            bus.clr_i      = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
            if ($urandom_range(0, 15) == 0) bus.irq_mask_i = NCH'($urandom);
            bus.wbs_stb_i  = ($urandom_range(0, 3) != 0);
            bus.wbs_ack_o  = bus.wbs_stb_i ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
